// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   - state_t          : controller states (IDLE, SHIFT, DONE)
//   - SUB_DEFAULT_BITS : default operand/result width
//   - sub_bit()        : one-bit full-subtractor step, returns {borrow_next, diff_bit}
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SUB_DEFAULT_BITS = 16;

  // Computes one bit of a - b - br and the borrow into the next bit.
  function automatic logic [1:0] sub_bit(input logic a_bit, input logic b_bit, input logic br);
    logic d;
    logic br_next;
    d       = a_bit ^ b_bit ^ br;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    return {br_next, d};
  endfunction

endpackage

// File: rtl/serial_subtractor_16bit_bit_counter.sv
// bit_counter
//   Up-counter with synchronous clear, count enable and a rollover flag at a
//   programmable value. Wraps to zero on the enabled edge where the count
//   equals rollover_val.
//   Ports:
//     clk            in   clock, rising edge
//     n_rst          in   asynchronous active-low reset
//     clear          in   synchronous clear to zero (wins over count_enable)
//     count_enable   in   advance the count by one
//     rollover_val   in   [CNT_W] terminal count value
//     rollover_flag  out  high while count equals rollover_val
module bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign rollover_flag = (count_reg == rollover_val);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      if (rollover_flag) begin
        count_next = '0;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
//   Bit-serial subtractor: diff = a - b - borrow_in, one result bit per clock,
//   LSB first, with a start/busy/done handshake.
//   Optional build macro SERIAL_SUB_SIGNED_OVF_EN adds a registered signed
//   overflow output.
//   Ports:
//     clk         in   clock, rising edge
//     n_rst       in   asynchronous active-low reset
//     start       in   request, sampled only in IDLE
//     a, b        in   [NUM_BITS] minuend / subtrahend, captured on accept
//     borrow_in   in   incoming borrow, captured on accept
//     busy        out  operation in flight (SHIFT or DONE)
//     done        out  one-cycle completion pulse
//     diff        out  [NUM_BITS] result register
//     borrow_out  out  final borrow (unsigned underflow)
//     overflow    out  signed overflow (only with SERIAL_SUB_SIGNED_OVF_EN)
module serial_subtractor_16bit
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = SUB_DEFAULT_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic                overflow
`endif
);

  localparam int CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  state_t state_reg, state_next;

  logic [NUM_BITS-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
  logic                br_reg;
  logic [NUM_BITS-1:0] diff_reg;
  logic                borrow_out_reg;

  logic [1:0] bit_pair;
  logic       d_bit;
  logic       br_next;
  logic       cnt_last;
  logic       accept;
  logic       finish;

  assign bit_pair = sub_bit(a_sh_reg[0], b_sh_reg[0], br_reg);
  assign d_bit    = bit_pair[0];
  assign br_next  = bit_pair[1];

  assign accept = (state_reg == IDLE) && start;
  // Last SHIFT edge: the counter has already seen NUM_BITS-1 bits.
  assign finish = (state_reg == SHIFT) && cnt_last;

  bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_reg != SHIFT),
    .count_enable  (state_reg == SHIFT),
    .rollover_val  (LAST_BIT),
    .rollover_flag (cnt_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // busy/done decode only the state register, so they stay free of input paths.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      res_sh_reg     <= '0;
      br_reg         <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
    end else if (accept) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      br_reg     <= borrow_in;
      res_sh_reg <= '0;
    end else if (state_reg == SHIFT) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      br_reg     <= br_next;
      res_sh_reg <= {d_bit, res_sh_reg[NUM_BITS-1:1]};
      if (finish) begin
        // The final bit is still in flight, so merge it here rather than
        // waiting a cycle for res_sh_reg to settle.
        diff_reg       <= {d_bit, res_sh_reg[NUM_BITS-1:1]};
        borrow_out_reg <= br_next;
      end
    end
  end

  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // Operand MSBs are shifted out during SHIFT, so keep copies for the
  // overflow decision taken on the final bit.
  logic a_msb_reg, b_msb_reg, overflow_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[NUM_BITS-1];
      b_msb_reg <= b[NUM_BITS-1];
    end else if (finish) begin
      overflow_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
    end
  end

  assign overflow = overflow_reg;
`endif

endmodule
